// File: rtl/lieat_ifu_ifetch_req_pkg.sv
// rtl/lieat_ifu_ifetch_req_pkg.sv - shared widths and next-PC select types for the fetch-request block
//
// Purpose : common widths (XLEN, REG_IDX), the next-PC source select
//           enumeration and a small alignment helper used by the fetch
//           request FSM and its target-address adder.
// Ports   : none (package).

package lieat_ifu_ifetch_req_pkg;

   localparam int XLEN    = 32;
   localparam int REG_IDX = 5;

   // Source of the next fetch address.
   typedef enum logic [1:0] {
      NPC_SEQ  = 2'd0,   // outstanding pc + 4
      NPC_BR   = 2'd1,   // outstanding pc + immediate
      NPC_JALR = 2'd2    // (rs1 + immediate) with bit 0 cleared
   } npc_sel_e;

   // jalr targets ignore bit 0 of the computed sum.
   function automatic logic [XLEN-1:0] clear_bit0(input logic [XLEN-1:0] addr);
      clear_bit0 = {addr[XLEN-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/lieat_ifu_ifetch_req_nextpc.sv
// rtl/lieat_ifu_ifetch_req_nextpc.sv - combinational next fetch-address adder
//
// Purpose : computes the next fetch address from the outstanding pc, the
//           decoded immediate and the rs1 value, according to sel.
//           All sums wrap modulo 2^XLEN.
// Ports   : pc        in  XLEN  pc of the instruction just returned
//           immb      in  XLEN  branch / jump offset
//           rs1_rdata in  XLEN  jalr base register value
//           sel       in  enum  which target to produce
//           target    out XLEN  next fetch address

module lieat_ifu_nextpc
   import lieat_ifu_ifetch_req_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] immb,
   input  logic [XLEN-1:0] rs1_rdata,
   input  npc_sel_e        sel,
   output logic [XLEN-1:0] target
);

   always_comb begin
      target = pc + XLEN'(4);
      unique case (sel)
         NPC_BR:   target = pc + immb;
         NPC_JALR: target = clear_bit0(rs1_rdata + immb);
         default:  target = pc + XLEN'(4);
      endcase
   end

endmodule

// File: rtl/lieat_ifu_ifetch_req.sv
// rtl/lieat_ifu_ifetch_req.sv - instruction-fetch request FSM with flush, stall and jalr hazard handling
//
// Purpose : issues one instruction-memory request at a time, forwards the
//           returned response together with its pc, and chooses the next
//           fetch address from same-cycle decode feedback (sequential,
//           branch, jalr, or serialize on csr/fence.i). An EXU flush
//           redirects fetch from any state; a response belonging to a
//           request issued before the flush is swallowed.
// Ports   : clk, rst_n                 clock, asynchronous active-low reset
//           req_o_valid/req_i_ready    fetch request handshake
//           req_o_pc                   fetch address
//           rsp_i_valid                memory response (one outstanding max)
//           rsp_o_valid/rsp_o_pc       forwarded response and its pc
//           dec_*                      decode feedback for the response
//           rs1_rdata/rs1_busy         jalr base value and its readiness
//           flush_i_valid/flush_i_pc   redirect from execute
//           ifu_i_stall                downstream full, hold off new requests

module lieat_ifu_ifetch_req
   import lieat_ifu_ifetch_req_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
)
(
   input  logic               clk,
   input  logic               rst_n,
   output logic               req_o_valid,
   input  logic               req_i_ready,
   output logic [XLEN-1:0]    req_o_pc,
   input  logic               rsp_i_valid,
   output logic               rsp_o_valid,
   output logic [XLEN-1:0]    rsp_o_pc,
   input  logic               dec_prdt_taken,
   input  logic               dec_rs1en,
   input  logic               dec_csr,
   input  logic               dec_fencei,
   input  logic [REG_IDX-1:0] dec_rs1,
   input  logic [XLEN-1:0]    dec_immb,
   input  logic [XLEN-1:0]    rs1_rdata,
   input  logic               rs1_busy,
   input  logic               flush_i_valid,
   input  logic [XLEN-1:0]    flush_i_pc,
   input  logic               ifu_i_stall
);

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_STALL = 3'd4
   } state_e;

   state_e             state;
   logic [XLEN-1:0]    pc;
   logic [XLEN-1:0]    out_pc;      // pc of the outstanding request
   logic               drop;        // outstanding response belongs to a flushed stream
   logic               hold_jalr;   // HOLD is waiting on rs1, not on a flush
   logic [XLEN-1:0]    hold_imm;
   logic [REG_IDX-1:0] hold_rs1;

   npc_sel_e           npc_sel;
   logic [XLEN-1:0]    npc_imm;
   logic [XLEN-1:0]    target;
   logic               jalr;
   logic               dec_hazard;
   logic               hold_hazard;
   logic               serialize;
   state_e             resume;

   // x0 is hard-wired, so a busy flag on it never blocks a jalr.
   assign jalr        = dec_prdt_taken & dec_rs1en;
   assign dec_hazard  = rs1_busy & (dec_rs1 != '0);
   assign hold_hazard = rs1_busy & (hold_rs1 != '0);
   assign serialize   = dec_csr | dec_fencei;
   assign resume      = ifu_i_stall ? ST_STALL : ST_REQ;

   assign req_o_valid = (state == ST_REQ);
   assign req_o_pc    = pc;
   assign rsp_o_pc    = out_pc;
   assign rsp_o_valid = (state == ST_WAIT) & rsp_i_valid & ~drop;

   // In HOLD the decode bus may already carry another instruction, so the
   // jalr offset is taken from the copy captured with the response.
   always_comb begin
      npc_sel = NPC_SEQ;
      npc_imm = dec_immb;
      if (state == ST_HOLD) begin
         npc_sel = NPC_JALR;
         npc_imm = hold_imm;
      end else if (jalr) begin
         npc_sel = NPC_JALR;
      end else if (dec_prdt_taken) begin
         npc_sel = NPC_BR;
      end
   end

   lieat_ifu_nextpc u_nextpc (
      .pc        (out_pc),
      .immb      (npc_imm),
      .rs1_rdata (rs1_rdata),
      .sel       (npc_sel),
      .target    (target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_BOOT;
         pc        <= RESET_PC;
         out_pc    <= '0;
         drop      <= 1'b0;
         hold_jalr <= 1'b0;
         hold_imm  <= '0;
         hold_rs1  <= '0;
      end else begin
         unique case (state)
            ST_BOOT: begin
               if (flush_i_valid) begin
                  pc    <= flush_i_pc;
                  state <= resume;
               end else begin
                  state <= ST_REQ;
               end
            end

            ST_REQ: begin
               if (req_i_ready) begin
                  out_pc <= pc;
                  state  <= ST_WAIT;
                  // Request already left: its response must be discarded.
                  if (flush_i_valid) begin
                     pc   <= flush_i_pc;
                     drop <= 1'b1;
                  end
               end else if (flush_i_valid) begin
                  pc    <= flush_i_pc;
                  state <= resume;
               end
            end

            ST_WAIT: begin
               if (rsp_i_valid) begin
                  drop <= 1'b0;
                  if (flush_i_valid) begin
                     pc    <= flush_i_pc;
                     state <= resume;
                  end else if (drop) begin
                     // pc already holds the flush target
                     state <= resume;
                  end else if (serialize) begin
                     hold_jalr <= 1'b0;
                     state     <= ST_HOLD;
                  end else if (jalr && dec_hazard) begin
                     hold_jalr <= 1'b1;
                     hold_imm  <= dec_immb;
                     hold_rs1  <= dec_rs1;
                     state     <= ST_HOLD;
                  end else begin
                     pc    <= target;
                     state <= resume;
                  end
               end else if (flush_i_valid) begin
                  pc   <= flush_i_pc;
                  drop <= 1'b1;
               end
            end

            ST_HOLD: begin
               if (flush_i_valid) begin
                  pc        <= flush_i_pc;
                  hold_jalr <= 1'b0;
                  state     <= resume;
               end else if (hold_jalr && !hold_hazard) begin
                  pc        <= target;
                  hold_jalr <= 1'b0;
                  state     <= resume;
               end
            end

            ST_STALL: begin
               if (flush_i_valid) begin
                  pc    <= flush_i_pc;
                  state <= resume;
               end else if (!ifu_i_stall) begin
                  state <= ST_REQ;
               end
            end

            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_lieat_ifu_ifetch_req.sv
// tb/tb_lieat_ifu_ifetch_req.sv - directed self-checking bench for lieat_ifu_ifetch_req

module tb_lieat_ifu_ifetch_req;

   logic        clk;
   logic        rst_n;
   logic        req_o_valid;
   logic        req_i_ready;
   logic [31:0] req_o_pc;
   logic        rsp_i_valid;
   logic        rsp_o_valid;
   logic [31:0] rsp_o_pc;
   logic        dec_prdt_taken;
   logic        dec_rs1en;
   logic        dec_csr;
   logic        dec_fencei;
   logic [4:0]  dec_rs1;
   logic [31:0] dec_immb;
   logic [31:0] rs1_rdata;
   logic        rs1_busy;
   logic        flush_i_valid;
   logic [31:0] flush_i_pc;
   logic        ifu_i_stall;

   int passed = 0;
   int total  = 0;

   lieat_ifu_ifetch_req #(.RESET_PC(32'h8000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_o_valid    (req_o_valid),
      .req_i_ready    (req_i_ready),
      .req_o_pc       (req_o_pc),
      .rsp_i_valid    (rsp_i_valid),
      .rsp_o_valid    (rsp_o_valid),
      .rsp_o_pc       (rsp_o_pc),
      .dec_prdt_taken (dec_prdt_taken),
      .dec_rs1en      (dec_rs1en),
      .dec_csr        (dec_csr),
      .dec_fencei     (dec_fencei),
      .dec_rs1        (dec_rs1),
      .dec_immb       (dec_immb),
      .rs1_rdata      (rs1_rdata),
      .rs1_busy       (rs1_busy),
      .flush_i_valid  (flush_i_valid),
      .flush_i_pc     (flush_i_pc),
      .ifu_i_stall    (ifu_i_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next falling edge: inputs change and
   // outputs are sampled here, half a period away from the rising edge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_i_ready    = 1'b0;
      rsp_i_valid    = 1'b0;
      dec_prdt_taken = 1'b0;
      dec_rs1en      = 1'b0;
      dec_csr        = 1'b0;
      dec_fencei     = 1'b0;
      dec_rs1        = 5'd0;
      dec_immb       = 32'd0;
      rs1_rdata      = 32'd0;
      rs1_busy       = 1'b0;
      flush_i_valid  = 1'b0;
      flush_i_pc     = 32'd0;
      ifu_i_stall    = 1'b0;
   endtask

   // Reset, release, and step once so the DUT sits in REQ at RESET_PC.
   task automatic boot();
      rst_n = 1'b0;
      clear_inputs();
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   // One cycle with req_i_ready high; leaves the DUT in WAIT.
   task automatic handshake();
      req_i_ready = 1'b1;
      cyc();
      req_i_ready = 1'b0;
   endtask

   task automatic respond(input logic tk, input logic rs1en, input logic csr,
                          input logic fi, input logic [31:0] imm);
      rsp_i_valid    = 1'b1;
      dec_prdt_taken = tk;
      dec_rs1en      = rs1en;
      dec_csr        = csr;
      dec_fencei     = fi;
      dec_immb       = imm;
      #1;
   endtask

   task automatic release_rsp();
      cyc();
      rsp_i_valid    = 1'b0;
      dec_prdt_taken = 1'b0;
      dec_rs1en      = 1'b0;
      dec_csr        = 1'b0;
      dec_fencei     = 1'b0;
      dec_rs1        = 5'd0;
      dec_immb       = 32'd0;
      flush_i_valid  = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      cyc();
      total++; if (req_o_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", req_o_valid); else passed++;
      total++; if (rsp_o_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_o_valid); else passed++;
      total++; if (rsp_o_pc !== 32'h0) $display("FAIL rst_rsp_pc: got %h want 00000000", rsp_o_pc); else passed++;
      total++; if (req_o_pc !== 32'h8000_0000) $display("FAIL rst_req_pc: got %h want 80000000", req_o_pc); else passed++;
      rst_n = 1'b1;
      #1;
      total++; if (req_o_valid !== 1'b0) $display("FAIL boot_no_req: got %b want 0", req_o_valid); else passed++;
      cyc();
      total++; if (req_o_valid !== 1'b1) $display("FAIL boot_req_valid: got %b want 1", req_o_valid); else passed++;
      total++; if (req_o_pc !== 32'h8000_0000) $display("FAIL boot_req_pc: got %h want 80000000", req_o_pc); else passed++;
   endtask

   task automatic test_sequential();
      boot();
      // request held without ready keeps its address
      cyc();
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_0000) $display("FAIL req_stable: got %b/%h want 1/80000000", req_o_valid, req_o_pc); else passed++;
      handshake();
      total++; if (req_o_valid !== 1'b0) $display("FAIL wait_no_req: got %b want 0", req_o_valid); else passed++;
      total++; if (rsp_o_pc !== 32'h8000_0000) $display("FAIL wait_rsp_pc: got %h want 80000000", rsp_o_pc); else passed++;
      respond(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      total++; if (rsp_o_valid !== 1'b1) $display("FAIL seq_rsp_valid: got %b want 1", rsp_o_valid); else passed++;
      release_rsp();
      total++; if (req_o_valid !== 1'b1) $display("FAIL seq_req_valid: got %b want 1", req_o_valid); else passed++;
      total++; if (req_o_pc !== 32'h8000_0004) $display("FAIL seq_pc: got %h want 80000004", req_o_pc); else passed++;
   endtask

   task automatic test_branch();
      boot();
      handshake();
      respond(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0);
      release_rsp();
      total++; if (req_o_pc !== 32'h7FFF_FFF0) $display("FAIL branch_pc: got %h want 7ffffff0", req_o_pc); else passed++;
   endtask

   task automatic test_jalr_ready();
      boot();
      handshake();
      dec_rs1   = 5'd7;
      rs1_rdata = 32'h0000_1235;
      respond(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004);
      release_rsp();
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h0000_1238) $display("FAIL jalr_pc: got %b/%h want 1/00001238", req_o_valid, req_o_pc); else passed++;
   endtask

   task automatic test_jalr_busy();
      boot();
      handshake();
      dec_rs1   = 5'd5;
      rs1_busy  = 1'b1;
      rs1_rdata = 32'h0000_0000;
      respond(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
      total++; if (rsp_o_valid !== 1'b1) $display("FAIL jalr_rsp_valid: got %b want 1", rsp_o_valid); else passed++;
      release_rsp();
      total++; if (req_o_valid !== 1'b0) $display("FAIL jalr_busy1: got %b want 0", req_o_valid); else passed++;
      cyc();
      total++; if (req_o_valid !== 1'b0) $display("FAIL jalr_busy2: got %b want 0", req_o_valid); else passed++;
      cyc();
      total++; if (req_o_valid !== 1'b0) $display("FAIL jalr_busy3: got %b want 0", req_o_valid); else passed++;
      rs1_busy  = 1'b0;
      rs1_rdata = 32'h8000_1001;
      cyc();
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_1010) $display("FAIL jalr_busy_pc: got %b/%h want 1/80001010", req_o_valid, req_o_pc); else passed++;
      rs1_rdata = 32'd0;
   endtask

   task automatic test_flush_wait();
      boot();
      handshake();
      flush_i_valid = 1'b1;
      flush_i_pc    = 32'h8000_2000;
      cyc();
      flush_i_valid = 1'b0;
      total++; if (req_o_valid !== 1'b0) $display("FAIL flushw_no_req: got %b want 0", req_o_valid); else passed++;
      respond(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      total++; if (rsp_o_valid !== 1'b0) $display("FAIL flushw_drop: got %b want 0", rsp_o_valid); else passed++;
      release_rsp();
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_2000) $display("FAIL flushw_pc: got %b/%h want 1/80002000", req_o_valid, req_o_pc); else passed++;
   endtask

   task automatic test_flush_handshake();
      boot();
      req_i_ready   = 1'b1;
      flush_i_valid = 1'b1;
      flush_i_pc    = 32'h8000_4000;
      cyc();
      req_i_ready   = 1'b0;
      flush_i_valid = 1'b0;
      respond(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      total++; if (rsp_o_valid !== 1'b0) $display("FAIL flushhs_drop: got %b want 0", rsp_o_valid); else passed++;
      release_rsp();
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_4000) $display("FAIL flushhs_pc: got %b/%h want 1/80004000", req_o_valid, req_o_pc); else passed++;
   endtask

   task automatic test_flush_with_rsp();
      boot();
      handshake();
      flush_i_valid = 1'b1;
      flush_i_pc    = 32'h8000_3000;
      respond(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
      total++; if (rsp_o_valid !== 1'b1) $display("FAIL flushrsp_valid: got %b want 1", rsp_o_valid); else passed++;
      release_rsp();
      total++; if (req_o_pc !== 32'h8000_3000) $display("FAIL flushrsp_pc: got %h want 80003000", req_o_pc); else passed++;
   endtask

   task automatic test_fencei_hold();
      int bad;
      boot();
      handshake();
      respond(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      release_rsp();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (req_o_valid !== 1'b0) bad++;
      end
      total++; if (bad !== 0) $display("FAIL fencei_hold: got %0d request cycles want 0", bad); else passed++;
      flush_i_valid = 1'b1;
      flush_i_pc    = 32'h8000_0104;
      cyc();
      flush_i_valid = 1'b0;
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_0104) $display("FAIL fencei_flush_pc: got %b/%h want 1/80000104", req_o_valid, req_o_pc); else passed++;
   endtask

   task automatic test_stall();
      boot();
      handshake();
      ifu_i_stall = 1'b1;
      respond(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      release_rsp();
      total++; if (req_o_valid !== 1'b0) $display("FAIL stall1: got %b want 0", req_o_valid); else passed++;
      cyc();
      total++; if (req_o_valid !== 1'b0) $display("FAIL stall2: got %b want 0", req_o_valid); else passed++;
      ifu_i_stall = 1'b0;
      cyc();
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_0004) $display("FAIL stall_resume: got %b/%h want 1/80000004", req_o_valid, req_o_pc); else passed++;
   endtask

   task automatic test_wrap();
      boot();
      flush_i_valid = 1'b1;
      flush_i_pc    = 32'hFFFF_FFFC;
      cyc();
      flush_i_valid = 1'b0;
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'hFFFF_FFFC) $display("FAIL req_flush_pc: got %b/%h want 1/fffffffc", req_o_valid, req_o_pc); else passed++;
      handshake();
      respond(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      release_rsp();
      total++; if (req_o_pc !== 32'h0000_0000) $display("FAIL wrap_pc: got %h want 00000000", req_o_pc); else passed++;
   endtask

   task automatic test_ignore_rsp();
      boot();
      rsp_i_valid = 1'b1;
      #1;
      total++; if (rsp_o_valid !== 1'b0) $display("FAIL stray_rsp_valid: got %b want 0", rsp_o_valid); else passed++;
      cyc();
      rsp_i_valid = 1'b0;
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_0000) $display("FAIL stray_rsp_state: got %b/%h want 1/80000000", req_o_valid, req_o_pc); else passed++;
   endtask

   task automatic test_reset_mid_wait();
      boot();
      handshake();
      rsp_i_valid = 1'b1;
      rst_n       = 1'b0;
      #1;
      total++; if (req_o_valid !== 1'b0 || rsp_o_valid !== 1'b0) $display("FAIL midrst_valid: got %b/%b want 0/0", req_o_valid, rsp_o_valid); else passed++;
      total++; if (rsp_o_pc !== 32'h0 || req_o_pc !== 32'h8000_0000) $display("FAIL midrst_pc: got %h/%h want 00000000/80000000", rsp_o_pc, req_o_pc); else passed++;
      cyc();
      rst_n = 1'b1;
      cyc();
      rsp_i_valid = 1'b0;
      total++; if (req_o_valid !== 1'b1 || req_o_pc !== 32'h8000_0000) $display("FAIL midrst_resume: got %b/%h want 1/80000000", req_o_valid, req_o_pc); else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_sequential();
      test_branch();
      test_jalr_ready();
      test_jalr_busy();
      test_flush_wait();
      test_flush_handshake();
      test_flush_with_rsp();
      test_fencei_hold();
      test_stall();
      test_wrap();
      test_ignore_rsp();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lieat_ifu_ifetch_req.md
LIEAT_IFU_IFETCH_REQ -- requirements
Module: lieat_ifu_ifetch_req

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset release.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; clears all state.
REQ-004 req_o_valid  output  1  instruction-memory fetch request valid.
REQ-005 req_i_ready  input  1  memory accepts request this cycle.
REQ-006 req_o_pc  output  XLEN  fetch address.
REQ-007 rsp_i_valid  input  1  memory returns instruction; at most one outstanding.
REQ-008 rsp_o_valid  output  1  forwarded response valid to fetch-response stage.
REQ-009 rsp_o_pc  output  XLEN  PC of forwarded response.
REQ-010 dec_prdt_taken, dec_rs1en, dec_csr, dec_fencei  input  1 each  same-cycle decode feedback from fetch-response stage.
REQ-011 dec_rs1  input  REG_IDX  jalr base register index (unused here except for hazard qualification).
REQ-012 dec_immb  input  XLEN  branch/jump offset.
REQ-013 rs1_rdata  input  XLEN  register-file value of dec_rs1; rs1_busy input 1 = value not yet valid.
REQ-014 flush_i_valid  input  1; flush_i_pc  input  XLEN  EXU redirect.
REQ-015 ifu_i_stall  input  1  downstream full; no new request issued.

Function
REQ-016 States: BOOT, REQ, WAIT, HOLD, STALL; one-hot or binary encoding free.
REQ-017 Reset values: state=BOOT, pc=RESET_PC, req_o_valid=0, rsp_o_valid=0, rsp_o_pc=0, drop=0.
REQ-018 BOOT -> REQ unconditionally on the first clock edge after reset deassertion.
REQ-019 REQ: req_o_valid=1, req_o_pc=pc; req_o_valid&req_i_ready -> WAIT, latching pc as outstanding PC.
REQ-020 req_o_pc stable while valid&!ready, except flush (REQ-026).
REQ-021 WAIT: rsp_o_valid = rsp_i_valid & !drop (combinational); rsp_o_pc = outstanding PC.
REQ-022 Next PC on non-dropped response, priority order: dec_csr|dec_fencei -> HOLD (serialize, wait for flush); dec_prdt_taken&dec_rs1en (jalr) -> rs1_rdata+dec_immb with bit0 cleared, or HOLD-jalr if rs1_busy; dec_prdt_taken -> outstanding PC+dec_immb; else outstanding PC+4.
REQ-023 All additions modulo 2^XLEN; wrap-around silent; bit1 misalignment not checked here.
REQ-024 After a response: ifu_i_stall=1 -> STALL, else REQ; req_o_valid asserts the cycle after rsp_i_valid (one-cycle issue latency).
REQ-025 STALL -> REQ when ifu_i_stall=0; HOLD-jalr recomputes target from rs1_rdata when rs1_busy drops and goes to REQ/STALL; HOLD for csr/fencei leaves only via flush.
REQ-026 flush_i_valid highest priority in every state: pc:=flush_i_pc, next state REQ (STALL if ifu_i_stall); in REQ without handshake the new pc replaces req_o_pc next cycle.
REQ-027 Flush while a request is outstanding (WAIT, or REQ handshake same cycle) sets drop; the matching response is consumed with rsp_o_valid=0, clears drop, then fetch proceeds from flush pc.
REQ-028 Flush coincident with a non-dropped response: flush wins, response still forwarded (rsp_o_valid=1), next pc=flush_i_pc.
REQ-029 rsp_i_valid outside WAIT is ignored (no state change, rsp_o_valid=0).

Reset
REQ-030 reset low at any time returns to REQ-017 values immediately, including mid-WAIT; a stale response arriving after release is ignored per REQ-029.
REQ-031 No synchronous reset path; no state retained across reset.

Structure
REQ-032 XLEN, REG_IDX from the shared lieat defines; state encodings local parameters in this module.
REQ-033 Target-address arithmetic in one combinational sub-module lieat_ifu_nextpc (inputs pc, immb, rs1_rdata, select; output target).

Verification
REQ-034 Reset release, req_i_ready=1 -> req_o_valid=1, req_o_pc=0x8000_0000 one cycle after BOOT.
REQ-035 Response for pc 0x8000_0000, not taken -> next req_o_pc=0x8000_0004; taken with immb=0xFFFF_FFF0 -> 0x7FFF_FFF0.
REQ-036 jalr, rs1_busy=1 for 3 cycles, rs1_rdata=0x8000_1001, immb=0x10 -> no request while busy, then req_o_pc=0x8000_1010.
REQ-037 Flush to 0x8000_2000 during WAIT -> following response gives rsp_o_valid=0, next req_o_pc=0x8000_2000.
REQ-038 dec_fencei response -> HOLD, req_o_valid=0 for 10 cycles; flush 0x8000_0104 -> request 0x8000_0104.
REQ-039 pc=0xFFFF_FFFC not taken -> next req_o_pc=0x0000_0000; reset asserted mid-WAIT -> outputs per REQ-017 in same cycle.
